// File: rtl/uart_tx_pkg.sv
// Shared types and widths for the UART TX line controller and its arbiter.
package uart_tx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_TRAIL
  } tx_state_e;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-requester round-robin arbiter; grants are combinational and only issued while i_en is high.
module uart_tx_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1 means requester 1 was granted last, so requester 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = r_last;
        o_gnt1 = !r_last;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (o_gnt0) begin
      r_last <= 1'b0;
    end else if (o_gnt1) begin
      r_last <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_line_ctrl.sv
// UART transmitter driving a tristate pad (tx_d/tx_e) with lead/trail enable guard bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_line_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned LEAD_BITS  = 1,
  parameter int unsigned TRAIL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              tx_d,
  output logic              tx_e,
  output logic              busy
);

  localparam logic [7:0] LEAD_LAST  = 8'(LEAD_BITS - 1);
  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_BITS - 1);
  localparam logic [7:0] DATA_LAST  = 8'(DATA_W - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [BAUD_W-1:0] r_div;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [7:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_data;
  logic              r_pend;
  logic              r_tx_d;
  logic              r_tx_e;
  logic              r_busy;
  logic              r_rdy0;
  logic              r_rdy1;
  logic              w_tx_d_nxt;
  logic              w_bit_end;
  logic              w_to_stop;
  logic              w_pre_last_stop;
  logic              w_slot;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;

`ifdef UART_TX_PARITY_EN
  logic r_par;
`endif

  // A back-to-back byte is granted one clock ahead so its ready pulse lands on the
  // last STOP clock; r_pend then forces that clock to close the bit even though
  // r_div already holds the new byte's divider.
  assign w_bit_end = r_pend || (r_baud_cnt == r_div);

`ifdef UART_TX_PARITY_EN
  assign w_to_stop = (r_state == ST_PARITY) && w_bit_end;
`else
  assign w_to_stop = (r_state == ST_DATA) && w_bit_end && (r_bit_cnt == DATA_LAST);
`endif

  assign w_pre_last_stop = (w_to_stop && (r_div == '0)) ||
                           ((r_state == ST_STOP) && !w_bit_end &&
                            ((r_baud_cnt + 16'd1) == r_div));
  assign w_slot   = (r_state == ST_IDLE) || w_pre_last_stop;
  assign w_accept = w_gnt0 || w_gnt1;
  assign w_data   = w_gnt0 ? req0_data : req1_data;

  uart_tx_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_slot),
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = (LEAD_BITS == 0) ? ST_START : ST_LEAD;
      end
      ST_LEAD: begin
        if (w_bit_end && (r_bit_cnt == LEAD_LAST)) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_pend)               w_state_nxt = ST_START;
          else if (TRAIL_BITS == 0) w_state_nxt = ST_IDLE;
          else                      w_state_nxt = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (w_bit_end && (r_bit_cnt == TRAIL_LAST)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = w_data;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  always_comb begin
    w_tx_d_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_d_nxt = 1'b0;
      ST_DATA:   w_tx_d_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_d_nxt = r_par;
`endif
      default:   w_tx_d_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_pend     <= 1'b0;
      r_tx_d     <= 1'b1;
      r_tx_e     <= 1'b0;
      r_busy     <= 1'b0;
      r_rdy0     <= 1'b0;
      r_rdy1     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_pend     <= w_accept && (r_state != ST_IDLE);
      r_baud_cnt <= ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_baud_cnt + 16'd1;
      if (w_accept) r_div <= baud_div;
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 8'd1;
      end
      r_tx_d <= w_tx_d_nxt;
      r_tx_e <= (w_state_nxt != ST_IDLE);
      r_busy <= (w_state_nxt != ST_IDLE);
      r_rdy0 <= w_gnt0;
      r_rdy1 <= w_gnt1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^w_data;
    end
  end
`endif

  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign tx_d       = r_tx_d;
  assign tx_e       = r_tx_e;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_tx_line_ctrl.sv
// Directed self-checking bench for uart_tx_line_ctrl: one default instance and one
// LEAD_BITS=0/TRAIL_BITS=0 instance; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_line_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] a_div, b_div;
  logic        a_v0, a_v1, b_v0, b_v1;
  logic [7:0]  a_d0, a_d1, b_d0, b_d1;
  logic        a_r0, a_r1, a_txd, a_txe, a_busy;
  logic        b_r0, b_r1, b_txd, b_txe, b_busy;

  uart_tx_line_ctrl #(.LEAD_BITS(1), .TRAIL_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .baud_div(a_div),
    .req0_valid(a_v0), .req0_data(a_d0), .req1_valid(a_v1), .req1_data(a_d1),
    .req0_ready(a_r0), .req1_ready(a_r1), .tx_d(a_txd), .tx_e(a_txe), .busy(a_busy)
  );

  uart_tx_line_ctrl #(.LEAD_BITS(0), .TRAIL_BITS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .baud_div(b_div),
    .req0_valid(b_v0), .req0_data(b_d0), .req1_valid(b_v1), .req1_data(b_d1),
    .req0_ready(b_r0), .req1_ready(b_r1), .tx_d(b_txd), .tx_e(b_txe), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int           n_run  = 0;
  int           n_fail = 0;
  logic [255:0] cap_vec, exp_vec;
  int           cap_len, exp_len, cap_r0, cap_r1, cap_r1_idx;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic b, input int n);
    repeat (n) begin
      exp_vec[exp_len] = b;
      exp_len++;
    end
  endtask

  // Reference waveform of one frame starting at START, bt clocks per bit.
  task automatic exp_frame(input logic [7:0] d, input int bt);
    exp_push(1'b0, bt);
    for (int k = 0; k < 8; k++) exp_push(d[k], bt);
`ifdef UART_TX_PARITY_EN
    exp_push(^d, bt);
`endif
    exp_push(1'b1, bt);
  endtask

  task automatic wait_ready(input bit sel_b, output bit got, output int which);
    logic r0, r1;
    got   = 1'b0;
    which = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      r0 = sel_b ? b_r0 : a_r0;
      r1 = sel_b ? b_r1 : a_r1;
      if (r0 || r1) begin
        got   = 1'b1;
        which = (r0 && r1) ? 2 : (r0 ? 0 : 1);
      end
    end
  endtask

  task automatic wait_idle(input bit sel_b, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (!(sel_b ? b_busy : a_busy)) got = 1'b1;
    end
  endtask

  // Records tx_d from the current negedge while tx_e stays high; acts as a
  // requester that drops valid on seeing its ready pulse.
  task automatic capture(input bit sel_b);
    logic e, d, r0, r1;
    bit   done;
    cap_vec = '0; cap_len = 0; cap_r0 = 0; cap_r1 = 0; cap_r1_idx = -1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      e  = sel_b ? b_txe : a_txe;
      d  = sel_b ? b_txd : a_txd;
      r0 = sel_b ? b_r0  : a_r0;
      r1 = sel_b ? b_r1  : a_r1;
      if (!e) begin
        done = 1'b1;
      end else begin
        if (cap_len < 256) cap_vec[cap_len] = d;
        cap_len++;
        if (r0) begin
          cap_r0++;
          if (sel_b) b_v0 = 1'b0; else a_v0 = 1'b0;
        end
        if (r1) begin
          cap_r1++;
          cap_r1_idx = i;
          if (sel_b) b_v1 = 1'b0; else a_v1 = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bit got;
    int which, hi_cnt;

    rst_n = 1'b0;
    a_div = 16'd3; b_div = 16'd0;
    a_v0 = 1'b0; a_v1 = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
    a_d0 = '0; a_d1 = '0; b_d0 = '0; b_d1 = '0;
    repeat (2) @(negedge clk);

    chk("rst_txe",  a_txe,  1'b0);
    chk("rst_txd",  a_txd,  1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rdy0", a_r0,   1'b0);
    chk("rst_rdy1", a_r1,   1'b0);
    chk("rst_b_txe", b_txe, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 at baud_div=3
    a_d0 = 8'hA5; a_v0 = 1'b1;
    wait_ready(1'b0, got, which);
    chk("single_ready", got, 1'b1);
    chk("single_grant", which, 0);
    chk("single_busy", a_busy, 1'b1);
    capture(1'b0);
    exp_vec = '0; exp_len = 0;
    exp_push(1'b1, 4); exp_frame(8'hA5, 4); exp_push(1'b1, 4);
`ifdef UART_TX_PARITY_EN
    chk("single_txe_clks", cap_len, 52);
`else
    chk("single_txe_clks", cap_len, 48);
`endif
    chk("single_wave", cap_vec, exp_vec);
    chk("single_rdy_pulses", cap_r0, 1);
    chk("single_idle_txd", a_txd, 1'b1);
    chk("single_idle_busy", a_busy, 1'b0);

    // Arbitration from a fresh reset with both requesters held
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    a_d0 = 8'h11; a_d1 = 8'h22; a_v0 = 1'b1; a_v1 = 1'b1;
    wait_ready(1'b0, got, which);
    chk("arb_first", which, 0);
    wait_ready(1'b0, got, which);
    chk("arb_second", which, 1);
    wait_ready(1'b0, got, which);
    chk("arb_third", which, 0);
    a_v0 = 1'b0; a_v1 = 1'b0;
    wait_idle(1'b0, got);
    chk("arb_idle", got, 1'b1);

    // Back-to-back: req1 raised during req0's frame
    a_d0 = 8'h3C; a_v0 = 1'b1;
    wait_ready(1'b0, got, which);
    chk("b2b_grant0", which, 0);
    a_d1 = 8'hC3; a_v1 = 1'b1;
    capture(1'b0);
    exp_vec = '0; exp_len = 0;
    exp_push(1'b1, 4); exp_frame(8'h3C, 4); exp_frame(8'hC3, 4); exp_push(1'b1, 4);
`ifdef UART_TX_PARITY_EN
    chk("b2b_txe_clks", cap_len, 96);
    chk("b2b_rdy1_at_last_stop", cap_r1_idx, 47);
`else
    chk("b2b_txe_clks", cap_len, 88);
    chk("b2b_rdy1_at_last_stop", cap_r1_idx, 43);
`endif
    chk("b2b_wave", cap_vec, exp_vec);
    chk("b2b_rdy1_pulses", cap_r1, 1);

    // Mid-frame reset during DATA
    a_d0 = 8'h00; a_v0 = 1'b1;
    wait_ready(1'b0, got, which);
    a_v0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_in_data_txd", a_txd, 1'b0);
    chk("mid_in_data_txe", a_txe, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_txe",  a_txe,  1'b0);
    chk("mid_rst_txd",  a_txd,  1'b1);
    chk("mid_rst_busy", a_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_txe || a_busy) hi_cnt++;
    end
    chk("mid_no_residual", hi_cnt, 0);

    // Parity bytes (frame length depends on the build option)
    a_d0 = 8'h07; a_v0 = 1'b1;
    wait_ready(1'b0, got, which);
    capture(1'b0);
`ifdef UART_TX_PARITY_EN
    chk("par07_len", cap_len, 52);
    chk("par07_bit", cap_vec[40], 1'b1);
`else
    chk("nopar07_len", cap_len, 48);
    chk("nopar07_stop", cap_vec[40], 1'b1);
`endif
    a_d0 = 8'h03; a_v0 = 1'b1;
    wait_ready(1'b0, got, which);
    capture(1'b0);
`ifdef UART_TX_PARITY_EN
    chk("par03_len", cap_len, 52);
    chk("par03_bit", cap_vec[40], 1'b0);
`else
    chk("nopar03_len", cap_len, 48);
    chk("nopar03_bit7", cap_vec[39], 1'b0);
`endif

    // Edge case: baud_div=0, LEAD_BITS=0, TRAIL_BITS=0
    b_d0 = 8'h5A; b_v0 = 1'b1;
    wait_ready(1'b1, got, which);
    chk("edge_ready", got, 1'b1);
    chk("edge_start_on_ready", b_txd, 1'b0);
    capture(1'b1);
    exp_vec = '0; exp_len = 0;
    exp_frame(8'h5A, 1);
`ifdef UART_TX_PARITY_EN
    chk("edge_txe_clks", cap_len, 11);
`else
    chk("edge_txe_clks", cap_len, 10);
`endif
    chk("edge_wave", cap_vec, exp_vec);
    chk("edge_idle_busy", b_busy, 1'b0);
    chk("edge_frame_bits", cap_len, FB);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
